div_bcd_converter: RTL and testbench
====================================

Name: div_bcd_converter

Overview:
- Downstream stage of the 8-bit divider.
- Captures the quotient (Coc), remainder (Res) and error flag (er) when the divider pulses done.
- Converts both values to packed BCD with a sequential shift-add-3 (double dabble), one bit per clock, both operands in parallel.
- Feeds the display/output logic with decimal digits plus an error flag.

Parameters:
- W, 8: binary operand width (matches divider Coc/Res width).
- DIGITS, 3: BCD digits per operand. Requires 10^DIGITS > 2^W-1. Not checked in RTL.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  capture request; connect to divider done.
- er  input  1  divider error flag (divide by zero), sampled with start.
- Coc  input  W  binary quotient, sampled with start.
- Res  input  W  binary remainder, sampled with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: results valid.
- err  output  1  latched error flag of the last completed request.
- Coc_bcd  output  4*DIGITS  packed BCD quotient; digit 0 in bits [3:0].
- Res_bcd  output  4*DIGITS  packed BCD remainder.

Behaviour:
- Reset (RST=1 at a rising edge, any state):
  - State goes to IDLE; internal shift and counter registers clear.
  - busy=0, done=0, err=0, Coc_bcd=0, Res_bcd=0.
  - RST has priority over start.
  - A conversion interrupted by reset is discarded and produces no done.
- States: IDLE, CONV.
- IDLE, start=1, er=0:
  - Latch Coc and Res into W-bit shift registers.
  - Clear both 4*DIGITS BCD accumulators; load bit counter with W.
  - Go to CONV; busy=1 from the next cycle.
- IDLE, start=1, er=1:
  - Stay in IDLE. At this same edge set err=1, Coc_bcd=0, Res_bcd=0, done=1.
  - Latency 1 cycle; busy stays 0.
- IDLE, start=0: hold; done=0.
- CONV, each edge, applied to each operand independently:
  - Every BCD digit >= 5 gets +3 (4-bit, no carry between digits).
  - Then shift the {bcd, bin} concatenation left by 1; bin MSB enters bcd LSB.
  - Decrement counter.
- CONV, last shift (counter==1 before the edge):
  - At that edge load Coc_bcd/Res_bcd with the final accumulator values, err=0, done=1, busy=0.
  - Return to IDLE.
- Latency, normal path: the start-sampling edge is edge 0; done is high in the cycle following edge W (8 cycles for W=8).
- done is high for exactly one cycle.
- Coc_bcd, Res_bcd and err hold their values until the next completion or reset.
- start while busy=1: ignored. No queuing; inputs are not re-sampled.
- start high in the cycle where done=1: accepted, since the state is already IDLE, giving back-to-back conversions with no dead cycle.
- Continuous start=1 in IDLE: a new conversion starts every W+1 cycles. Each one samples the Coc, Res and er present at its own start edge.
- Zero operands: convert to all-zero BCD; a normal done pulse follows after W cycles.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. RST=1 for 2 cycles, then release -> all outputs 0. Then start=1 for 1 cycle with Coc=5, Res=0, er=0 -> done pulse 8 cycles later, Coc_bcd=12'h005, Res_bcd=12'h000, err=0. busy=1 for exactly 8 cycles.
2. start with Coc=255, Res=254 -> Coc_bcd=12'h255, Res_bcd=12'h254. Then Coc=99, Res=10 -> 12'h099, 12'h010.
3. start with er=1, Coc=0xAB, Res=0xCD -> next cycle done=1, err=1, Coc_bcd=0, Res_bcd=0, busy never asserted. A following valid start (Coc=6, Res=0) clears err to 0 at its done.
4. start with Coc=30, Res=7, then a second start 3 cycles later with Coc=200 -> second start ignored. Single done at 8 cycles with 12'h030/12'h007.
5. start with Coc=123, Res=45; RST=1 at cycle 4 -> no done pulse, outputs 0, busy=0. A start after release converts correctly.
6. Drive start=1 in the done cycle with Coc=0, Res=0 -> second done exactly 8 cycles later with 12'h000/12'h000, err=0.

Source files
------------

// File: rtl/div_bcd_converter.sv
// Divider back end: captures quotient/remainder/error and converts both operands to packed BCD
// with a bit-serial double dabble, one bit per clock, both operands in parallel.

module div_bcd_lane #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic [W-1:0]        bin_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [W-1:0]        bin_o
);
  logic [4*DIGITS-1:0] adj;

  // Each digit is corrected independently; >=5 becomes >=8 so the shift carries into the next digit.
  always_comb begin
    adj = bcd_i;
    for (int d = 0; d < DIGITS; d++)
      if (bcd_i[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_i[4*d +: 4] + 4'd3;
  end

  assign {bcd_o, bin_o} = {adj[4*DIGITS-2:0], bin_i, 1'b0};
endmodule

module div_bcd_converter #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                er,
  input  logic [W-1:0]        Coc,
  input  logic [W-1:0]        Res,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4*DIGITS-1:0] Coc_bcd,
  output logic [4*DIGITS-1:0] Res_bcd
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                                 state;
  logic [CW-1:0]                          cnt;
  logic [NUM_LANES-1:0][W-1:0]            bin_q, bin_n;
  logic [NUM_LANES-1:0][4*DIGITS-1:0]     bcd_q, bcd_n;

  // Lane 0 carries the quotient, lane 1 the remainder.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    div_bcd_lane #(.W(W), .DIGITS(DIGITS)) u_lane (
      .bcd_i (bcd_q[g]),
      .bin_i (bin_q[g]),
      .bcd_o (bcd_n[g]),
      .bin_o (bin_n[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      Coc_bcd <= '0;
      Res_bcd <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (er) begin
              err     <= 1'b1;
              Coc_bcd <= '0;
              Res_bcd <= '0;
              done    <= 1'b1;
            end else begin
              bin_q <= {Res, Coc};
              bcd_q <= '0;
              cnt   <= CW'(W);
              busy  <= 1'b1;
              state <= CONV;
            end
          end
        end
        CONV: begin
          bin_q <= bin_n;
          bcd_q <= bcd_n;
          cnt   <= cnt - CW'(1);
          // Final shift: publish the post-shift accumulators directly so done lands after edge W.
          if (cnt == CW'(1)) begin
            Coc_bcd <= bcd_n[0];
            Res_bcd <= bcd_n[1];
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_bcd_converter.sv
// Self-checking bench for div_bcd_converter: vector table plus scoreboard queue checked on done.

module tb_div_bcd_converter;
  localparam int W = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        er = 1'b0;
  logic [7:0]  Coc = '0, Res = '0;
  logic        busy, done, err;
  logic [11:0] Coc_bcd, Res_bcd;

  div_bcd_converter #(.W(W), .DIGITS(3)) dut (
    .CLK(CLK), .RST(RST), .start(start), .er(er), .Coc(Coc), .Res(Res),
    .busy(busy), .done(done), .err(err), .Coc_bcd(Coc_bcd), .Res_bcd(Res_bcd)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] c;
    logic [11:0] r;
    logic        e;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0]  coc;
    logic [7:0]  res;
    logic        er;
    logic [11:0] exp_c;
    logic [11:0] exp_r;
    logic        exp_e;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("coc_bcd", int'(Coc_bcd), int'(x.c));
        chk("res_bcd", int'(Res_bcd), int'(x.r));
        chk("err", int'(err), int'(x.e));
        chk("done_cycle", cyc, x.due);
      end
    end
  end

  // Call at a negedge; returns one negedge later with start released.
  task automatic issue(input logic [7:0] c, input logic [7:0] r, input logic e,
                       input logic [11:0] ec, input logic [11:0] erx, input logic ee, input bit track);
    exp_t x;
    Coc = c; Res = r; er = e; start = 1'b1;
    x.c = ec; x.r = erx; x.e = ee; x.due = cyc + 1 + (e ? 0 : W);
    if (track) q.push_back(x);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_coc"}, int'(Coc_bcd), 0);
    chk({tag, "_res"}, int'(Res_bcd), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   bc;

    vt.push_back('{8'd255, 8'd254, 1'b0, 12'h255, 12'h254, 1'b0});
    vt.push_back('{8'd99,  8'd10,  1'b0, 12'h099, 12'h010, 1'b0});
    vt.push_back('{8'hAB,  8'hCD,  1'b1, 12'h000, 12'h000, 1'b1});
    vt.push_back('{8'd6,   8'd0,   1'b0, 12'h006, 12'h000, 1'b0});
    vt.push_back('{8'd128, 8'd64,  1'b0, 12'h128, 12'h064, 1'b0});
    vt.push_back('{8'd0,   8'd199, 1'b0, 12'h000, 12'h199, 1'b0});

    // Reset state
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_idle_zero("reset");

    // Basic conversion with busy-length check
    issue(8'd5, 8'd0, 1'b0, 12'h005, 12'h000, 1'b0, 1);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) bc++;
      @(negedge CLK);
    end
    chk("busy_cycles", bc, 8);
    drain();

    // Table vectors, including error path followed by a clearing conversion
    foreach (vt[i]) begin
      issue(vt[i].coc, vt[i].res, vt[i].er, vt[i].exp_c, vt[i].exp_r, vt[i].exp_e, 1);
      if (vt[i].er) begin
        bc = 0;
        for (int k = 0; k < 3; k++) begin
          if (busy) bc++;
          @(negedge CLK);
        end
        chk("err_path_busy", bc, 0);
      end
      drain();
    end

    // Random vectors against the decimal model
    for (int i = 0; i < 6; i++) begin
      int a, b;
      logic e;
      a = $urandom_range(255); b = $urandom_range(255);
      e = ($urandom_range(3) == 0);
      issue(8'(a), 8'(b), e, e ? 12'h000 : to_bcd(a), e ? 12'h000 : to_bcd(b), e, 1);
      drain();
    end

    // start while busy is ignored
    issue(8'd30, 8'd7, 1'b0, 12'h030, 12'h007, 1'b0, 1);
    repeat (2) @(negedge CLK);
    issue(8'd200, 8'd1, 1'b0, 12'h0, 12'h0, 1'b0, 0);
    drain();
    repeat (12) @(negedge CLK);

    // Reset mid-conversion discards the request
    issue(8'd123, 8'd45, 1'b0, 12'h0, 12'h0, 1'b0, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_idle_zero("midreset");
    repeat (12) @(negedge CLK);
    chk("midreset_busy_after", int'(busy), 0);
    issue(8'd123, 8'd45, 1'b0, 12'h123, 12'h045, 1'b0, 1);
    drain();

    // Back-to-back: new start driven in the done cycle
    issue(8'd77, 8'd3, 1'b0, 12'h077, 12'h003, 1'b0, 1);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (done) begin
          seen = 1;
          issue(8'd0, 8'd0, 1'b0, 12'h000, 12'h000, 1'b0, 1);
        end else begin
          @(negedge CLK);
        end
      end
      chk("b2b_done_seen", int'(seen), 1);
    end
    drain();

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
